// File: rtl/key_pulse_gen_pkg.sv
// Shared constants for the PS/2 key pulse generator: set-2 scancodes,
// held-register bit positions, counter width and the code-to-key decoder.
package key_pulse_gen_pkg;

  // PS/2 set-2 prefixes and the game key codes
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Bit positions in the held register
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_ROT   = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_DROP  = 4;
  localparam int NUM_KEYS  = 5;

  // Repeat counter width
  localparam int CNT_W = 8;

  // One-hot key selected by a completed code; zero for unmapped codes.
  // Arrows only count when extended, Space only when not extended, so the
  // keypad aliases of the arrow codes fall through to zero.
  function automatic logic [NUM_KEYS-1:0] map_key(input logic ext, input logic [7:0] code);
    logic [NUM_KEYS-1:0] hit;
    hit = '0;
    if (ext) begin
      case (code)
        SC_LEFT:  hit[KEY_LEFT]  = 1'b1;
        SC_RIGHT: hit[KEY_RIGHT] = 1'b1;
        SC_UP:    hit[KEY_ROT]   = 1'b1;
        SC_DOWN:  hit[KEY_DOWN]  = 1'b1;
        default:  hit = '0;
      endcase
    end else if (code == SC_SPACE) begin
      hit[KEY_DROP] = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// DAS/ARR auto-repeat for one key. Counts tick_game strobes while the key is
// held and not inhibited; emits rep_pulse combinationally on the qualifying
// tick so the parent can register it together with the make pulse.
module key_repeat
  import key_pulse_gen_pkg::*;
#(
  parameter logic [CNT_W-1:0] DAS_TICKS = 8'd10,
  parameter logic [CNT_W-1:0] ARR_TICKS = 8'd2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic held,       // held bit after this cycle's byte is applied
  input  logic make,       // fresh make of this key (was not held)
  input  logic inhibit,    // left and right both held
  input  logic tick_game,
  output logic rep_pulse
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arr_q, arr_d;   // 0: DAS phase, 1: ARR phase
  logic [CNT_W-1:0] cnt_inc;

  // Next counter/phase; a make or break in the same cycle overrides the tick
  always_comb begin
    cnt_d     = cnt_q;
    arr_d     = arr_q;
    rep_pulse = 1'b0;
    cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    if (!held || make || inhibit) begin
      cnt_d = '0;
      arr_d = 1'b0;
    end else if (tick_game) begin
      if (cnt_inc == (arr_q ? ARR_TICKS : DAS_TICKS)) begin
        rep_pulse = 1'b1;
        cnt_d     = '0;
        arr_d     = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Counter and phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      arr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      arr_q <= arr_d;
    end
  end

endmodule

// File: rtl/key_pulse_gen.sv
// PS/2 set-2 scancode stream to game key pulses and soft-drop level.
// Optional feature macro: KEY_REPEAT_EN enables DAS/ARR auto-repeat on
// left/right; without it left/right give only the make pulse.
// Handshake: scan_valid is a one-cycle strobe with no back-pressure; every
// strobed byte is consumed in the cycle it is presented.
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int unsigned DAS_TICKS = 10,
  parameter int unsigned ARR_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       tick_game,
  output logic       key_left,
  output logic       key_right,
  output logic       key_rotate,
  output logic       key_drop,
  output logic       key_down
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_e;

  prefix_e             state_q, state_d;
  logic                is_final, is_ext, is_brk;
  logic [NUM_KEYS-1:0] key_hit, held_q, held_d, fresh;
  logic                rep_left, rep_right;
  logic [3:0]          pulse_q, pulse_d;   // {drop, rotate, right, left}

  // Prefix FSM: tracks E0/F0 prefixes and flags the byte completing a code
  always_comb begin
    state_d  = state_q;
    is_final = 1'b0;
    is_ext   = 1'b0;
    is_brk   = 1'b0;
    if (scan_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_code == SC_E0)      state_d = ST_EXT;
          else if (scan_code == SC_F0) state_d = ST_BRK;
          else                         is_final = 1'b1;
        end
        ST_EXT: begin
          if (scan_code == SC_F0) begin
            state_d = ST_EXT_BRK;
          end else if (scan_code != SC_E0) begin
            is_final = 1'b1;
            is_ext   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          is_final = 1'b1;
          is_brk   = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          is_final = 1'b1;
          is_ext   = 1'b1;
          is_brk   = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Held-register update and make pulses; typematic re-makes give no pulse
  always_comb begin
    key_hit = is_final ? map_key(is_ext, scan_code) : '0;
    held_d  = held_q;
    fresh   = '0;
    if (is_final && is_brk) begin
      held_d = held_q & ~key_hit;
    end else if (is_final) begin
      held_d = held_q | key_hit;
      fresh  = key_hit & ~held_q;
    end
    pulse_d = {fresh[KEY_DROP], fresh[KEY_ROT],
               fresh[KEY_RIGHT] | rep_right, fresh[KEY_LEFT] | rep_left};
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] DAS_THR = CNT_W'(DAS_TICKS);
  localparam logic [CNT_W-1:0] ARR_THR = CNT_W'(ARR_TICKS);
  logic both_held;
  assign both_held = held_d[KEY_LEFT] & held_d[KEY_RIGHT];

  key_repeat #(.DAS_TICKS(DAS_THR), .ARR_TICKS(ARR_THR)) u_rep_left (
    .clk       (clk),
    .rst_n     (rst_n),
    .held      (held_d[KEY_LEFT]),
    .make      (fresh[KEY_LEFT]),
    .inhibit   (both_held),
    .tick_game (tick_game),
    .rep_pulse (rep_left)
  );

  key_repeat #(.DAS_TICKS(DAS_THR), .ARR_TICKS(ARR_THR)) u_rep_right (
    .clk       (clk),
    .rst_n     (rst_n),
    .held      (held_d[KEY_RIGHT]),
    .make      (fresh[KEY_RIGHT]),
    .inhibit   (both_held),
    .tick_game (tick_game),
    .rep_pulse (rep_right)
  );
`else
  // Repeat disabled: the tick strobe and timing parameters have no effect
  logic unused_cfg;
  assign unused_cfg = ^{tick_game, 8'(DAS_TICKS), 8'(ARR_TICKS)};
  assign rep_left   = 1'b0;
  assign rep_right  = 1'b0;
`endif

  // State, held bits and registered pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
    end
  end

  assign key_left   = pulse_q[0];
  assign key_right  = pulse_q[1];
  assign key_rotate = pulse_q[2];
  assign key_drop   = pulse_q[3];
  assign key_down   = held_q[KEY_DOWN];

endmodule
